// File: rtl/wb_regfile.sv
// wb_regfile: writeback stage and architectural register file.
//
// Picks the writeback value from the MEM/WB slot (load data or ALU result)
// and commits it to a 32 x DATA_W register file. Two combinational ID read
// ports see a write presented in the same cycle (write-first bypass). The
// live writeback is exported for the EX forwarding unit. A retired
// instruction counter counts every valid MEM/WB slot.
//
// Ports:
//   clk, rst        pipeline clock; synchronous active-high reset
//   wb_valid        MEM/WB slot holds a real instruction (0 = bubble)
//   wb_read_data    load data
//   wb_alu_result   ALU result
//   wb_reg_dest     destination register number
//   wb_mem_to_reg   1 = write load data, 0 = write ALU result
//   wb_reg_write    instruction writes a register
//   rs_addr/rs_data ID read port A
//   rt_addr/rt_data ID read port B
//   fwd_we/fwd_addr/fwd_data  current writeback for EX forwarding
//   retired_count   valid instructions retired since reset (wraps)
module wb_regfile #(
  parameter int          DATA_W  = 32,
  parameter int          ADDR_W  = 5,
  // Value loaded into retired_count by reset; the pipeline uses 0.
  parameter logic [31:0] CNT_RST = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  input  logic [DATA_W-1:0] wb_read_data,
  input  logic [DATA_W-1:0] wb_alu_result,
  input  logic [ADDR_W-1:0] wb_reg_dest,
  input  logic              wb_mem_to_reg,
  input  logic              wb_reg_write,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              fwd_we,
  output logic [ADDR_W-1:0] fwd_addr,
  output logic [DATA_W-1:0] fwd_data,
  output logic [31:0]       retired_count
);

  localparam int NREGS = 1 << ADDR_W;

  // Register 0 is hardwired to zero, so no storage exists for it.
  logic [DATA_W-1:0] regs [1:NREGS-1];
  logic [31:0]       retired_q;
  logic [DATA_W-1:0] wb_value;
  logic              we;

  assign wb_value = wb_mem_to_reg ? wb_read_data : wb_alu_result;
  // Bubbles, $zero targets and the reset cycle never write or bypass.
  assign we       = wb_valid & wb_reg_write & (wb_reg_dest != '0) & ~rst;

  assign fwd_we        = we;
  assign fwd_addr      = rst ? '0 : wb_reg_dest;
  assign fwd_data      = rst ? '0 : wb_value;
  assign retired_count = retired_q;

  // ---- commit edge: register array and retirement counter ----
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      retired_q <= CNT_RST;
    end else begin
      if (we) begin
        regs[wb_reg_dest] <= wb_value;
      end
      if (wb_valid) begin
        retired_q <= retired_q + 32'd1;
      end
    end
  end

  // Read ports: $zero first, then the in-flight write, then the array.
  always_comb begin
    rs_data = '0;
    if (rs_addr == '0) begin
      rs_data = '0;
    end else if (we && (rs_addr == wb_reg_dest)) begin
      rs_data = wb_value;
    end else begin
      rs_data = regs[rs_addr];
    end
  end

  always_comb begin
    rt_data = '0;
    if (rt_addr == '0) begin
      rt_data = '0;
    end else if (we && (rt_addr == wb_reg_dest)) begin
      rt_data = wb_value;
    end else begin
      rt_data = regs[rt_addr];
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic [31:0] wb_read_data;
  logic [31:0] wb_alu_result;
  logic [4:0]  wb_reg_dest;
  logic        wb_mem_to_reg;
  logic        wb_reg_write;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;

  logic [31:0] rs_data,  rt_data,  fwd_data,  retired_count;
  logic        fwd_we;
  logic [4:0]  fwd_addr;
  logic [31:0] rs_data2, rt_data2, fwd_data2, retired_count2;
  logic        fwd_we2;
  logic [4:0]  fwd_addr2;

  localparam logic [31:0] CNT_RST2 = 32'hFFFF_FFFD;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_read_data(wb_read_data),
    .wb_alu_result(wb_alu_result), .wb_reg_dest(wb_reg_dest),
    .wb_mem_to_reg(wb_mem_to_reg), .wb_reg_write(wb_reg_write),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
    .fwd_we(fwd_we), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .retired_count(retired_count)
  );

  // Second instance starts its counter just below the wrap point.
  wb_regfile #(.CNT_RST(CNT_RST2)) u_wrap (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_read_data(wb_read_data),
    .wb_alu_result(wb_alu_result), .wb_reg_dest(wb_reg_dest),
    .wb_mem_to_reg(wb_mem_to_reg), .wb_reg_write(wb_reg_write),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data2), .rt_data(rt_data2),
    .fwd_we(fwd_we2), .fwd_addr(fwd_addr2), .fwd_data(fwd_data2),
    .retired_count(retired_count2)
  );

  typedef struct {
    logic [31:0] rs;
    logic [31:0] rt;
    logic        fwe;
    logic [4:0]  fa;
    logic [31:0] fd;
    logic [31:0] cnt;
    logic [31:0] cnt2;
  } exp_t;

  exp_t sbq[$];

  // Reference model: architectural state as plain variables.
  logic [31:0] mregs [32];
  logic [31:0] mcnt;
  logic [31:0] mcnt2;

  int nchecks = 0;
  int nerrs   = 0;
  int cyc     = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrs++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: every cycle the outputs are settled, compare against the oldest
  // expectation posted by the driver.
  exp_t me;
  always @(negedge clk) begin
    while (sbq.size() > 0) begin
      me = sbq.pop_front();
      chk("rs_data",        rs_data,                 me.rs);
      chk("rt_data",        rt_data,                 me.rt);
      chk("fwd_we",         {31'd0, fwd_we},         {31'd0, me.fwe});
      chk("fwd_addr",       {27'd0, fwd_addr},       {27'd0, me.fa});
      chk("fwd_data",       fwd_data,                me.fd);
      chk("retired_count",  retired_count,           me.cnt);
      chk("wrap_rs_data",   rs_data2,                me.rs);
      chk("wrap_rt_data",   rt_data2,                me.rt);
      chk("wrap_fwd_we",    {31'd0, fwd_we2},        {31'd0, me.fwe});
      chk("wrap_fwd_data",  fwd_data2,               me.fd);
      chk("wrap_fwd_addr",  {27'd0, fwd_addr2},      {27'd0, me.fa});
      chk("wrap_retired",   retired_count2,          me.cnt2);
    end
  end

  function automatic logic [31:0] model_read(input logic [4:0] a, input logic we,
                                             input logic [4:0] d, input logic [31:0] v);
    if (a == 5'd0) return 32'd0;
    if (we && a == d) return v;
    return mregs[a];
  endfunction

  // One pipeline cycle: apply inputs, post the expected outputs, take the edge,
  // then advance the model by the architectural rules.
  task automatic step(input logic r, input logic v, input logic rw, input logic m2r,
                      input logic [4:0] d, input logic [31:0] alu, input logic [31:0] rdat,
                      input logic [4:0] ra, input logic [4:0] rb, input bit post);
    exp_t e;
    logic we;
    logic [31:0] val;
    rst = r; wb_valid = v; wb_reg_write = rw; wb_mem_to_reg = m2r;
    wb_reg_dest = d; wb_alu_result = alu; wb_read_data = rdat;
    rs_addr = ra; rt_addr = rb;
    val = m2r ? rdat : alu;
    we  = !r && v && rw && (d != 5'd0);
    if (post) begin
      e.rs   = model_read(ra, we, d, val);
      e.rt   = model_read(rb, we, d, val);
      e.fwe  = we;
      e.fa   = r ? 5'd0 : d;
      e.fd   = r ? 32'd0 : val;
      e.cnt  = mcnt;
      e.cnt2 = mcnt2;
      sbq.push_back(e);
    end
    @(posedge clk);
    cyc++;
    if (r) begin
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
      mcnt  = 32'd0;
      mcnt2 = CNT_RST2;
    end else begin
      if (v) begin
        mcnt  = mcnt + 32'd1;
        mcnt2 = mcnt2 + 32'd1;
      end
      if (we) mregs[d] = val;
    end
    #1;
  endtask

  task automatic rd(input logic [4:0] ra, input logic [4:0] rb);
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, ra, rb, 1'b1);
  endtask

  initial begin
    logic [4:0] d, ra, rb;
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    mcnt = 32'd0; mcnt2 = CNT_RST2;
    @(posedge clk); #1;
    // Array contents are unknown until the first reset edge.
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b1);

    // Preload every writable register with a nonzero value.
    for (int i = 1; i < 32; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 5'(i), $urandom | 32'h1, 32'd0,
           5'($urandom_range(0, 31)), 5'(i), 1'b1);
    end
    rd(5'd5, 5'd7);

    // Reset with a live write in the slot: reads still see the array, no bypass.
    step(1'b1, 1'b1, 1'b1, 1'b0, 5'd5, 32'hDEAD_BEEF, 32'd0, 5'd5, 5'd7, 1'b1);
    for (int i = 0; i < 32; i += 2) rd(5'(i), 5'(i + 1));

    // Writeback select.
    step(1'b0, 1'b1, 1'b1, 1'b1, 5'd8, 32'h0000_1234, 32'hCAFE_0000, 5'd8, 5'd0, 1'b1);
    rd(5'd8, 5'd8);
    step(1'b0, 1'b1, 1'b1, 1'b0, 5'd8, 32'h0000_1234, 32'hCAFE_0000, 5'd0, 5'd8, 1'b1);
    rd(5'd8, 5'd8);

    // Bypass on both ports, with the other port reading an untouched register.
    step(1'b0, 1'b1, 1'b1, 1'b0, 5'd4, 32'h4444_0004, 32'd0, 5'd0, 5'd0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 5'd3, 32'h55AA_55AA, 32'd0, 5'd3, 5'd3, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 5'd3, 32'h0BAD_0003, 32'd0, 5'd3, 5'd4, 1'b1);
    rd(5'd3, 5'd4);

    // $zero target: no write, no bypass, still retires.
    step(1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 5'd0, 1'b1);
    rd(5'd0, 5'd0);

    // Bubble with a write-looking payload.
    step(1'b0, 1'b1, 1'b1, 1'b0, 5'd9, 32'h9999_0009, 32'd0, 5'd9, 5'd0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 5'd9, 32'h1111_1111, 32'h1111_1111, 5'd9, 5'd9, 1'b1);
    rd(5'd9, 5'd9);

    // Valid non-writing instruction retires without writing.
    step(1'b0, 1'b1, 1'b0, 1'b1, 5'd10, 32'h0A0A_0A0A, 32'h0B0B_0B0B, 5'd10, 5'd10, 1'b1);
    rd(5'd10, 5'd10);

    // Randomized traffic with occasional mid-stream resets.
    for (int n = 0; n < 600; n++) begin
      d  = 5'($urandom_range(0, 31));
      ra = ($urandom_range(0, 2) == 0) ? d : 5'($urandom_range(0, 31));
      rb = ($urandom_range(0, 2) == 0) ? d : 5'($urandom_range(0, 31));
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 3) != 0), 1'($urandom), d, $urandom, $urandom,
           ra, rb, 1'b1);
    end

    // Drain the scoreboard within a bounded number of cycles.
    for (int k = 0; k < 8 && sbq.size() > 0; k++) @(negedge clk);
    #1;
    nchecks++;
    if (sbq.size() != 0) begin
      nerrs++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback stage and architectural register file for the 5-stage MIPS pipeline. Consumes the MEM/WB pipeline-register outputs, selects the writeback value (load data or ALU result), and commits it to a 32 x 32-bit register file. It serves the ID stage's two read ports with same-cycle write-through bypass. It also exports the live writeback value for EX-stage forwarding and keeps a retired-instruction counter.

## Interface
- DATA_W, 32, datapath width
- ADDR_W, 5, register address width (32 registers)
- clk  in  1  pipeline clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- wb_valid  in  1  MEM/WB slot holds a real instruction (0 = bubble)
- wb_read_data  in  DATA_W  load data from MEM/WB
- wb_alu_result  in  DATA_W  ALU result from MEM/WB
- wb_reg_dest  in  ADDR_W  destination register number
- wb_mem_to_reg  in  1  1 = write load data, 0 = write ALU result
- wb_reg_write  in  1  instruction writes a register
- rs_addr  in  ADDR_W  ID read port A address
- rt_addr  in  ADDR_W  ID read port B address
- rs_data  out  DATA_W  read port A data
- rt_data  out  DATA_W  read port B data
- fwd_we  out  1  effective write enable this cycle (for EX forwarding unit)
- fwd_addr  out  ADDR_W  destination of the current writeback
- fwd_data  out  DATA_W  value being written this cycle
- retired_count  out  32  number of valid instructions retired since reset

## Operation
- Writeback select: wb_value = wb_mem_to_reg ? wb_read_data : wb_alu_result.
- Effective write: we = wb_valid & wb_reg_write & (wb_reg_dest != 0) & ~rst.
- fwd_we = we; fwd_addr = wb_reg_dest; fwd_data = wb_value. All three are combinational and drive 0 when rst = 1.
- Register array: on a rising edge with we = 1, regs[wb_reg_dest] <= wb_value. No other write path exists.
- Register 0 is hardwired: it is never written, and reads of address 0 return 0 regardless of bypass.
- Read ports are combinational. For each port p with address a:
  - if a == 0, data = 0;
  - else if we and a == wb_reg_dest, data = wb_value (write-first bypass);
  - else data = regs[a].
- Both ports are independent. Both may bypass the same write simultaneously.
- retired_count increments by 1 on each rising edge where wb_valid = 1 and rst = 0. This includes valid instructions with wb_reg_write = 0 and writes targeting $zero. The counter wraps from 0xFFFF_FFFF to 0.
- Bubbles (wb_valid = 0) cause no write and no count, and do not bypass, even if other wb_* inputs are nonzero.

## Timing
- Reset: on a rising edge with rst = 1, all 31 writable registers are cleared to 0 and retired_count is cleared to 0. Any write or count presented in that cycle is discarded, since reset wins over a simultaneous write.
- During rst = 1, rs_data and rt_data still read the array combinationally (no bypass). After the reset edge they return 0. fwd_we is 0.
- Write latency: the value is visible through bypass in the same cycle it is presented. It is visible from the array on the cycle after the edge.
- Read latency: 0 cycles (combinational); no handshake and no stall generation.
- Back-to-back writes to the same register: the last edge wins. A read in each cycle returns that cycle's incoming value.
- Reset mid-stream: in-flight MEM/WB contents in the reset cycle are lost. The first valid instruction after rst deasserts counts as retired_count = 1.

## Test plan
- Reset: preload regs 1..31 with nonzero values, assert rst for 1 cycle alongside wb_valid=1, wb_reg_write=1, dest=5, alu=0xDEAD_BEEF. Required: all reads return 0, retired_count = 0, fwd_we = 0 during reset.
- Select and write: wb_valid=1, wb_reg_write=1, dest=8, alu=0x0000_1234, read_data=0xCAFE_0000, mem_to_reg=1. Required: after the edge, rs_addr=8 gives 0xCAFE_0000. Repeat with mem_to_reg=0: reg 8 holds 0x0000_1234.
- Bypass: same cycle write dest=3, value 0x55AA_55AA, with rs_addr=3 and rt_addr=3. Required: both ports return 0x55AA_55AA before the edge. rt_addr=4 returns the old reg 4 value.
- $zero: write dest=0, value 0xFFFF_FFFF, with rs_addr=0. Required: rs_data=0 in that cycle and after; fwd_we=0; retired_count still increments.
- Bubble: wb_valid=0, wb_reg_write=1, dest=9, value 0x1111_1111. Required: reg 9 unchanged, no bypass, fwd_we=0, retired_count unchanged.
- Counter wrap: force retired_count to 0xFFFF_FFFF via 2^32-1 valid cycles (or a bench backdoor), then present 1 valid cycle. Required: retired_count = 0x0000_0000.
